// File: rtl/spi_slave_rx_multi.sv
// Oversampled SPI slave receiver: all four SPI modes, configurable word width and bit order.
// Splits multi-word frames into channel-tagged words delivered over a valid/ready handshake.
module spi_slave_rx_multi #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CHANNELS    = 4,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CHAN_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_nss,
  input  logic                  spi_clock_in,
  input  logic                  spi_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CHAN_WIDTH-1:0] channel_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  overrun,
  input  logic                  overrun_clear
);

  localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LastBit = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CHAN_WIDTH-1:0] LastChan = CHAN_WIDTH'(CHANNELS - 1);

  typedef enum logic {StIdle, StReceive} state_e;

  logic [SYNC_STAGES-1:0] nss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   nss_s, sclk_s, mosi_s;
  logic                   sample_edge;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CHAN_WIDTH-1:0]  chan_cnt_q, chan_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic [CHAN_WIDTH-1:0]  word_chan_q, word_chan_d;
  logic                   word_stb_q, word_stb_d;
  logic                   frame_error_q, frame_error_d;

  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic [CHAN_WIDTH-1:0]  channel_out_q, channel_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   load_ok;

  assign nss_s  = nss_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  assign sample_edge = ~nss_s & ((CPOL == CPHA) ? (sclk_s & ~sclk_dly_q)
                                                : (~sclk_s & sclk_dly_q));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    chan_cnt_d    = chan_cnt_q;
    shift_d       = shift_q;
    word_d        = word_q;
    word_chan_d   = word_chan_q;
    word_stb_d    = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!nss_s) begin
          state_d    = StReceive;
          bit_cnt_d  = '0;
          chan_cnt_d = '0;
        end
      end
      StReceive: begin
        if (bit_cnt_q == LastBit) begin
          // A full word is committed even if nss rises in the same cycle.
          word_d      = shift_q;
          word_chan_d = chan_cnt_q;
          word_stb_d  = 1'b1;
          bit_cnt_d   = '0;
          chan_cnt_d  = (chan_cnt_q == LastChan) ? '0 : chan_cnt_q + CHAN_WIDTH'(1);
          if (nss_s) begin
            state_d    = StIdle;
            chan_cnt_d = '0;
          end
        end else if (nss_s) begin
          state_d       = StIdle;
          bit_cnt_d     = '0;
          chan_cnt_d    = '0;
          frame_error_d = (bit_cnt_q != '0);
        end else if (sample_edge) begin
          shift_d   = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A load may coincide with the consumer taking the current word.
  assign load_ok = ~data_valid_q | data_ready;

  always_comb begin
    data_out_d    = data_out_q;
    channel_out_d = channel_out_q;
    data_valid_d  = data_valid_q;
    frame_done_d  = 1'b0;
    overrun_d     = overrun_q;
    if (word_stb_q) begin
      if (load_ok) begin
        data_out_d    = word_q;
        channel_out_d = word_chan_q;
        data_valid_d  = 1'b1;
        frame_done_d  = (word_chan_q == LastChan);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
    if (overrun_clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      nss_sync_q    <= '0;
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      sclk_dly_q    <= 1'b0;
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      chan_cnt_q    <= '0;
      shift_q       <= '0;
      word_q        <= '0;
      word_chan_q   <= '0;
      word_stb_q    <= 1'b0;
      frame_error_q <= 1'b0;
      data_out_q    <= '0;
      channel_out_q <= '0;
      data_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      nss_sync_q    <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss};
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clock_in};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], spi_data_in};
      sclk_dly_q    <= sclk_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      chan_cnt_q    <= chan_cnt_d;
      shift_q       <= shift_d;
      word_q        <= word_d;
      word_chan_q   <= word_chan_d;
      word_stb_q    <= word_stb_d;
      frame_error_q <= frame_error_d;
      data_out_q    <= data_out_d;
      channel_out_q <= channel_out_d;
      data_valid_q  <= data_valid_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data_out    = data_out_q;
  assign channel_out = channel_out_q;
  assign data_valid  = data_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx_multi.sv
// Directed bench for spi_slave_rx_multi: five DUT configurations driven one at a time by an SPI
// master task, checked every cycle against a queue of expected deliveries.
module tb_spi_slave_rx_multi;

  localparam int NUM  = 5;
  localparam int SYNC = 2;
  localparam int HALF = 5;  // core cycles per SPI half period

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [NUM-1:0] nss  = '1;
  logic [NUM-1:0] sclk = 5'b01100;  // instances 2 and 3 idle high
  logic [NUM-1:0] mosi = '0;
  logic data_ready = 1'b1;
  logic overrun_clear = 1'b0;

  logic [15:0]    dout [NUM];
  logic [1:0]     chan [NUM];
  logic [NUM-1:0] dv, fd, ferr, ovr;

  always #5 clock = ~clock;

  // Instances: 0..3 = SPI modes 0..3 (16-bit MSB first), 4 = mode 0, 12-bit LSB first.
  for (genvar g = 0; g < NUM; g++) begin : g_dut
    localparam int unsigned DW = (g == 4) ? 12 : 16;
    localparam bit POL = (g == 2 || g == 3);
    localparam bit PHA = (g == 1 || g == 3);
    localparam bit MSB = (g != 4);
    logic [DW-1:0] d;
    spi_slave_rx_multi #(
      .DATA_WIDTH(DW), .CHANNELS(4), .CPOL(POL), .CPHA(PHA), .MSB_FIRST(MSB),
      .SYNC_STAGES(SYNC)
    ) u_dut (
      .clock(clock), .reset(reset), .spi_nss(nss[g]), .spi_clock_in(sclk[g]),
      .spi_data_in(mosi[g]), .data_out(d), .channel_out(chan[g]), .data_valid(dv[g]),
      .data_ready(data_ready), .frame_done(fd[g]), .frame_error(ferr[g]),
      .overrun(ovr[g]), .overrun_clear(overrun_clear)
    );
    assign dout[g] = 16'(d);
  end

  typedef struct {
    logic [15:0] data;
    int          ch;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          act = 0, cyc = 0, last_cyc = 0;
  int          model_ch = 0, exp_err = 0, err_seen = 0, fd_seen = 0;
  bit          lat_check = 1'b0;
  logic [15:0] last_data = '0;
  int          last_ch = -1;
  logic        prev_dv = 1'b0, prev_hs = 1'b0;
  event        sample_done;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t inst=%0d)", name, got, want, $time, act);
    end
  endtask

  // Compare process: whenever a word is presented it must be the head of the expected queue.
  always @(negedge clock) begin
    logic newload;
    if (reset) begin
      newload = dv[act] && (!prev_dv || prev_hs);
      if (ferr[act]) err_seen++;
      if (fd[act]) fd_seen++;
      if (dv[act]) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'd0, dv[act]}, 32'd0);
        end else begin
          check("data", dout[act], exp_q[0].data);
          check("channel", chan[act], exp_q[0].ch);
          check("frame_done", fd[act], newload && exp_q[0].ch == 3);
          if (newload && lat_check) begin
            // Sample transition driven after posedge P0; valid seen after P0 + SYNC + 3.
            check("latency", cyc - last_cyc, SYNC + 3);
            lat_check = 1'b0;
          end
          if (data_ready) begin
            last_data = exp_q[0].data;
            last_ch   = exp_q[0].ch;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("frame_done_idle", fd[act], 0);
      end
      prev_dv = dv[act];
      prev_hs = dv[act] && data_ready;
    end else begin
      prev_dv = 1'b0;
      prev_hs = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int nbits);
    int dw;
    bit msb, pha;
    logic b;
    dw  = (act == 4) ? 12 : 16;
    msb = (act != 4);
    pha = (act == 1 || act == 3);
    for (int k = 0; k < nbits; k++) begin
      b = msb ? w[dw-1-k] : w[k];
      if (!pha) begin
        mosi[act] = b;
        tick(HALF);
        sclk[act] = ~sclk[act];
        if (k == nbits - 1) begin
          last_cyc = cyc;
          -> sample_done;
        end
        tick(HALF);
        sclk[act] = ~sclk[act];
      end else begin
        tick(HALF);
        sclk[act] = ~sclk[act];
        mosi[act] = b;
        tick(HALF);
        sclk[act] = ~sclk[act];
        if (k == nbits - 1) begin
          last_cyc = cyc;
          -> sample_done;
        end
      end
    end
  endtask

  task automatic frame_begin();
    model_ch = 0;
    nss[act] = 1'b0;
    tick(HALF);
  endtask

  task automatic send_word(input logic [15:0] w, input bit deliver);
    exp_t e;
    if (deliver) begin
      e.data = w;
      e.ch   = model_ch;
      exp_q.push_back(e);
    end
    model_ch = (model_ch + 1) % 4;
    send_bits(w, (act == 4) ? 12 : 16);
  endtask

  task automatic frame_end(input int tail_bits);
    if (tail_bits > 0) begin
      send_bits(16'hFFFF, tail_bits);
      exp_err++;
    end
    tick(HALF);
    nss[act] = 1'b1;
    tick(4 * HALF);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pattern [4];
    pattern[0] = 16'h1111;
    pattern[1] = 16'h2222;
    pattern[2] = 16'h3333;
    pattern[3] = 16'h4444;

    tick(4);
    for (int i = 0; i < NUM; i++) begin
      check("reset_valid", dv[i], 0);
      check("reset_data", dout[i], 0);
      check("reset_overrun", ovr[i], 0);
    end
    reset = 1'b1;
    tick(5);

    // Mode 0, single word, latency measured.
    act = 0;
    lat_check = 1'b1;
    frame_begin();
    send_word(16'hA5C3, 1'b1);
    frame_end(0);
    check("m0_word_literal", last_data, 16'hA5C3);
    check("m0_chan_literal", last_ch, 0);
    check("m0_latency_done", lat_check, 0);

    // Modes 1..3: four-channel frames.
    for (int m = 1; m <= 3; m++) begin
      act = m;
      fd_seen = 0;
      frame_begin();
      for (int w = 0; w < 4; w++) send_word(pattern[w], 1'b1);
      frame_end(0);
      check("mode_last_literal", last_data, 16'h4444);
      check("mode_last_chan", last_ch, 3);
      check("mode_frame_done_count", fd_seen, 1);
      check("mode_overrun", ovr[m], 0);
      check("mode_drained", exp_q.size(), 0);
    end

    // Truncated word: frame_error, and the next frame restarts at channel 0.
    act = 0;
    frame_begin();
    send_word(16'h00FF, 1'b1);
    frame_end(7);
    check("trunc_error_count", err_seen, 1);
    frame_begin();
    send_word(16'hBEEF, 1'b1);
    frame_end(0);
    check("trunc_next_chan", last_ch, 0);
    check("trunc_next_data", last_data, 16'hBEEF);

    // Overrun: consumer stalled while two words arrive.
    data_ready = 1'b0;
    frame_begin();
    send_word(16'h1234, 1'b1);
    send_word(16'h5678, 1'b0);
    frame_end(0);
    check("ovr_set", ovr[0], 1);
    check("ovr_hold_data", dout[0], 16'h1234);
    check("ovr_hold_valid", dv[0], 1);
    overrun_clear = 1'b1;
    tick(1);
    overrun_clear = 1'b0;
    check("ovr_cleared", ovr[0], 0);

    // Consume and load in the same cycle: no overrun, valid never drops.
    fork
      begin
        frame_begin();
        send_word(16'h9ABC, 1'b1);
        frame_end(0);
      end
      begin
        @(sample_done);
        repeat (SYNC + 2) @(posedge clock);
        #2 data_ready = 1'b1;
      end
    join
    check("simul_no_overrun", ovr[0], 0);
    check("simul_data", last_data, 16'h9ABC);
    check("simul_drained", exp_q.size(), 0);

    // Reset in the middle of a word.
    frame_begin();
    send_bits(16'hFFFF, 9);
    reset = 1'b0;
    tick(3);
    check("rst_data", dout[0], 0);
    check("rst_chan", chan[0], 0);
    check("rst_valid", dv[0], 0);
    check("rst_frame_done", fd[0], 0);
    check("rst_frame_error", ferr[0], 0);
    check("rst_overrun", ovr[0], 0);
    nss[0] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(4 * HALF);
    frame_begin();
    send_word(16'h0F0F, 1'b1);
    frame_end(0);
    check("rst_after_data", last_data, 16'h0F0F);
    check("rst_no_error", err_seen, 1);

    // LSB first, 12-bit: serial 1,0,...,0,1.
    act = 4;
    frame_begin();
    send_word(16'h0801, 1'b1);
    frame_end(0);
    check("lsb_literal", last_data, 16'h0801);

    check("final_drained", exp_q.size(), 0);
    check("final_errors", err_seen, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
